// File: rtl/line_fill_sequencer.sv
// Ping-pong scanline buffer write controller: fetches the next line into the
// bank scanout is not reading, swapping banks on each scanout line start.
module line_fill_sequencer #(
  parameter int unsigned DATA_WIDTH        = 16,
  parameter int unsigned BUFFER_ADDR_WIDTH = 8,
  parameter int unsigned LINE_WORDS        = 128,
  parameter int unsigned LINE_COUNT_WIDTH  = 10,
  parameter int unsigned LAST_LINE         = 479
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         frame_start,
  input  logic                         line_start,
  output logic                         fetch_req,
  output logic [LINE_COUNT_WIDTH-1:0]  fetch_line,
  input  logic                         fetch_ack,
  input  logic                         in_valid,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  output logic [BUFFER_ADDR_WIDTH-1:0] buf_write_addr,
  output logic [DATA_WIDTH-1:0]        buf_write_data,
  output logic                         buf_write_enable,
  output logic                         read_bank,
  output logic                         underrun,
  output logic                         busy
);

  localparam int unsigned WCW = BUFFER_ADDR_WIDTH - 1;
  localparam logic [WCW-1:0]              LAST_WORD_C = WCW'(LINE_WORDS - 1);
  localparam logic [LINE_COUNT_WIDTH-1:0] LAST_LINE_C = LINE_COUNT_WIDTH'(LAST_LINE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQUEST,
    S_FILL,
    S_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic [LINE_COUNT_WIDTH-1:0]  line_q, line_d;
  logic [WCW-1:0]               wcnt_q, wcnt_d;
  logic                         pend_q, pend_d;
  logic                         read_bank_q, read_bank_d;
  logic                         underrun_q, underrun_d;
  logic                         fetch_req_q, fetch_req_d;
  logic                         in_ready_q, in_ready_d;
  logic                         busy_q, busy_d;
  logic                         wr_en_q, wr_en_d;
  logic [BUFFER_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]        wr_data_q, wr_data_d;
  logic                         accept;

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    wcnt_d      = wcnt_q;
    pend_d      = pend_q;
    read_bank_d = read_bank_q;
    underrun_d  = underrun_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    accept      = in_valid & in_ready_q;
    wr_en_d     = accept;

    if (accept) begin
      wr_addr_d = {~read_bank_q, wcnt_q};
      wr_data_d = in_data;
    end

    unique case (state_q)
      S_IDLE: begin
        if (frame_start && enable) begin
          line_d      = '0;
          read_bank_d = 1'b1;
          underrun_d  = 1'b0;
          pend_d      = 1'b0;
          state_d     = S_REQUEST;
        end
      end
      S_REQUEST: begin
        if (line_start)  underrun_d = 1'b1;
        if (frame_start) pend_d     = 1'b1;
        if (fetch_ack) begin
          wcnt_d  = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (line_start)  underrun_d = 1'b1;
        if (frame_start) pend_d     = 1'b1;
        if (accept) begin
          if (wcnt_q == LAST_WORD_C) begin
            state_d = S_DONE;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (frame_start) pend_d = 1'b1;
        if (line_start) begin
          // The toggle always happens so scanout shows the line just filled;
          // a pending frame start then restarts the fetch sequence at line 0.
          read_bank_d = ~read_bank_q;
          if (pend_q || frame_start) begin
            line_d     = '0;
            underrun_d = 1'b0;
            pend_d     = 1'b0;
            state_d    = S_REQUEST;
          end else if (enable && (line_q < LAST_LINE_C)) begin
            line_d  = line_q + 1'b1;
            state_d = S_REQUEST;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    fetch_req_d = (state_d == S_REQUEST);
    in_ready_d  = (state_d == S_FILL);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      line_q      <= '0;
      wcnt_q      <= '0;
      pend_q      <= 1'b0;
      read_bank_q <= 1'b0;
      underrun_q  <= 1'b0;
      fetch_req_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      wcnt_q      <= wcnt_d;
      pend_q      <= pend_d;
      read_bank_q <= read_bank_d;
      underrun_q  <= underrun_d;
      fetch_req_q <= fetch_req_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign fetch_req        = fetch_req_q;
  assign fetch_line       = line_q;
  assign in_ready         = in_ready_q;
  assign buf_write_addr   = wr_addr_q;
  assign buf_write_data   = wr_data_q;
  assign buf_write_enable = wr_en_q;
  assign read_bank        = read_bank_q;
  assign underrun         = underrun_q;
  assign busy             = busy_q;

endmodule

// File: doc/line_fill_sequencer.md
# line_fill_sequencer

Single-clock controller that owns the write port of the scanline dual-port buffer and runs it as a ping-pong pair of banks. Scanout reads one bank while this block fetches the next scanline's pixel words from the memory fetch stream into the other bank. Banks swap on the scanout line-start pulse. Fill late relative to line start is reported as underrun.

## Interface
- DATA_WIDTH, 16, pixel word width; matches buffer.
- BUFFER_ADDR_WIDTH, 8, buffer address width; MSB selects bank.
- LINE_WORDS, 128, words per scanline; 1 ≤ LINE_WORDS ≤ 2^(BUFFER_ADDR_WIDTH-1).
- LINE_COUNT_WIDTH, 10, width of line index.
- LAST_LINE, 479, index of final visible line.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low.
- enable  in  1  permits starting frames/lines.
- frame_start  in  1  one-cycle pulse, start of frame.
- line_start  in  1  one-cycle pulse, scanout begins a new line.
- fetch_req  out  1  request to fetch line fetch_line.
- fetch_line  out  LINE_COUNT_WIDTH  line index requested.
- fetch_ack  in  1  fetch request accepted.
- in_valid  in  1  stream word valid.
- in_data  in  DATA_WIDTH  stream word.
- in_ready  out  1  block accepts stream word.
- buf_write_addr  out  BUFFER_ADDR_WIDTH  to buffer write_addr.
- buf_write_data  out  DATA_WIDTH  to buffer write_data.
- buf_write_enable  out  1  to buffer write_enable.
- read_bank  out  1  bank scanout reads; scanout's read_addr MSB.
- underrun  out  1  sticky: line_start arrived before fill completed.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, REQUEST, FILL, DONE. fill_bank = ~read_bank always.
- Reset (asserted): state IDLE; line counter 0; word counter 0; pending-frame flag 0; every output 0 (read_bank=0, underrun=0).
- IDLE: frame_start & enable → line=0, read_bank←1 (fill bank 0), underrun←0, → REQUEST. frame_start with enable low ignored. line_start ignored.
- REQUEST: fetch_req=1, fetch_line=line. fetch_ack sampled high → word counter 0, → FILL. fetch_req held until ack.
- FILL: in_ready=1. Each in_valid & in_ready: write word to {fill_bank, word counter}; counter+1. Acceptance of word LINE_WORDS-1 → DONE.
- DONE: in_ready=0. On line_start: read_bank toggles; then if pending-frame set → apply frame start (as IDLE case, clears flag); else if enable and line < LAST_LINE → line+1, → REQUEST; else → IDLE.
- line_start in REQUEST or FILL: underrun←1; read_bank unchanged (scanout repeats prior bank); fill continues; pulse not retained.
- frame_start in REQUEST/FILL/DONE: sets pending-frame flag; no abort of the stream in progress. In DONE the frame start is applied on the next line_start after the toggle; in REQUEST/FILL, applied after the fill completes and the next line_start arrives.
- underrun cleared only by reset or an applied frame start.
- Word counter is BUFFER_ADDR_WIDTH-1 bits; never wraps within a line (terminates at LINE_WORDS-1).

## Timing
- All outputs registered on rising clk.
- Stream accept at edge N → buf_write_enable=1 with addr/data for cycle N+1 only; buffer samples on the falling edge mid-cycle N+1 (half-cycle setup margin).
- Back-to-back valid: one word per cycle, no bubbles. Line fill minimum = 1 (req/ack) + LINE_WORDS cycles.
- fetch_req rises the cycle after entering REQUEST and falls the cycle after fetch_ack.
- in_ready falls the cycle after the final word is accepted; in_valid then is not accepted.
- read_bank toggles the cycle after the line_start edge sampled in DONE.
- Reset deassertion mid-fill: block resumes in IDLE; the partially written bank is unused until refilled.

## Test plan
- Reset then frame_start, enable=1, LINE_WORDS=4, stream 0xA0..0xA3 with fetch_ack 1 cycle after fetch_req → fetch_line=0; writes to addresses 0x00..0x03 with the matching data; read_bank=1; busy=1 in DONE.
- Continuing: line_start → read_bank=0, fetch_line=1, writes to 0x80..0x83.
- Stream with in_valid toggled every other cycle → exactly 4 writes, no duplicates, counter stalls correctly.
- line_start during FILL after 2 of 4 words → underrun=1, read_bank unchanged, fill completes to 0x83; next line_start toggles read_bank.
- LAST_LINE=1: after line 1 fills, line_start → read_bank toggles, state IDLE, busy=0, no fetch_req.
- reset asserted mid-FILL → all outputs 0 immediately (asynchronous); frame_start after release restarts at line 0, bank 0.
